// File: rtl/alu_pkg.sv
// Shared constants, opcode encoding and FSM state type for the ALU command sequencer.
package alu_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned SHIFT_W  = 5;
    localparam int unsigned FLAG_W   = 3;

    localparam logic [OPCODE_W-1:0] ADD = 4'd0;
    localparam logic [OPCODE_W-1:0] SUB = 4'd1;
    localparam logic [OPCODE_W-1:0] AND = 4'd2;
    localparam logic [OPCODE_W-1:0] OR  = 4'd3;

    localparam logic [OPCODE_W-1:0] MAX_LEGAL_OP = 4'd3;

    // Bit positions inside rsp_flags = {carry, zero, overflow}
    localparam int unsigned CARRY = 2;
    localparam int unsigned ZERO  = 1;
    localparam int unsigned OVF   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
        return op <= MAX_LEGAL_OP;
    endfunction

    function automatic logic is_arith(input logic [OPCODE_W-1:0] op);
        return (op == ADD) || (op == SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response signals of the sequencer bundled into one interface.
interface alu_cmd_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [alu_pkg::OPCODE_W-1:0]  cmd_opcode;
    logic [WIDTH-1:0]              cmd_a;
    logic [WIDTH-1:0]              cmd_b;
    logic [alu_pkg::SHIFT_W-1:0]   cmd_shift;

    logic [alu_pkg::OPCODE_W-1:0]  alu_opcode;
    logic [WIDTH-1:0]              alu_input1;
    logic [WIDTH-1:0]              alu_input2;
    logic [alu_pkg::SHIFT_W-1:0]   alu_shiftValue;
    logic [WIDTH-1:0]              alu_result;
    logic                          alu_carry;
    logic                          alu_zero;
    logic                          alu_overflow;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [WIDTH-1:0]              rsp_result;
    logic [alu_pkg::FLAG_W-1:0]    rsp_flags;
    logic                          rsp_illegal;

    logic                          busy;
    logic [$clog2(DEPTH):0]        fifo_level;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift,
        input  alu_result, alu_carry, alu_zero, alu_overflow,
        input  rsp_ready,
        output cmd_ready,
        output alu_opcode, alu_input1, alu_input2, alu_shiftValue,
        output rsp_valid, rsp_result, rsp_flags, rsp_illegal,
        output busy, fifo_level
    );

    // Producer / ALU / consumer side
    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift,
        output alu_result, alu_carry, alu_zero, alu_overflow,
        output rsp_ready,
        input  cmd_ready,
        input  alu_opcode, alu_input1, alu_input2, alu_shiftValue,
        input  rsp_valid, rsp_result, rsp_flags, rsp_illegal,
        input  busy, fifo_level
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pushes are ignored when full, pops ignored when empty.
module alu_cmd_fifo #(
    parameter int unsigned DW    = 21,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [DW-1:0]          wdata_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == LVL_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues one at a time onto registered ALU inputs and
// captures the combinational ALU result into a backpressured response register.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_cmd_sequencer_if.slave  bus
);
    localparam int unsigned CMD_W = OPCODE_W + WIDTH + WIDTH + SHIFT_W;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    state_e              state_q;
    state_e              state_d;
    logic                pop_c;
    logic                capture_c;
    logic                rsp_clr_c;

    logic [CMD_W-1:0]    fifo_wdata;
    logic [CMD_W-1:0]    fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [LVL_W-1:0]    fifo_level;

    logic [OPCODE_W-1:0] alu_opcode_q;
    logic [WIDTH-1:0]    alu_a_q;
    logic [WIDTH-1:0]    alu_b_q;
    logic [SHIFT_W-1:0]  alu_shift_q;

    logic                rsp_valid_q;
    logic [WIDTH-1:0]    rsp_result_q;
    logic [WIDTH-1:0]    rsp_result_d;
    logic [FLAG_W-1:0]   rsp_flags_q;
    logic [FLAG_W-1:0]   rsp_flags_d;
    logic                rsp_illegal_q;
    logic                rsp_illegal_d;

    assign fifo_wdata = {bus.cmd_opcode, bus.cmd_a, bus.cmd_b, bus.cmd_shift};

    alu_cmd_fifo #(
        .DW    (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.cmd_valid),
        .wdata_i (fifo_wdata),
        .pop_i   (pop_c),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = fifo_empty ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop_c     = 1'b0;
        capture_c = 1'b0;
        rsp_clr_c = 1'b0;
        case (state_q)
            IDLE:  pop_c = !fifo_empty;
            ISSUE: capture_c = 1'b1;
            RESP: begin
                rsp_clr_c = bus.rsp_ready;
                pop_c     = bus.rsp_ready && !fifo_empty;
            end
            default: ;
        endcase
    end

    // ALU operand registers only change on a pop, so they hold in IDLE/RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_shift_q  <= '0;
        end else if (pop_c) begin
            {alu_opcode_q, alu_a_q, alu_b_q, alu_shift_q} <= fifo_rdata;
        end
    end

    // Logic ops report only zero; illegal opcodes ignore the ALU entirely
    always_comb begin
        rsp_result_d  = '0;
        rsp_flags_d   = '0;
        rsp_illegal_d = 1'b0;
        if (!is_legal(alu_opcode_q)) begin
            rsp_flags_d[ZERO] = 1'b1;
            rsp_illegal_d     = 1'b1;
        end else begin
            rsp_result_d      = bus.alu_result;
            rsp_flags_d[ZERO] = bus.alu_zero;
            if (is_arith(alu_opcode_q)) begin
                rsp_flags_d[CARRY] = bus.alu_carry;
                rsp_flags_d[OVF]   = bus.alu_overflow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_illegal_q <= 1'b0;
        end else if (capture_c) begin
            rsp_valid_q   <= 1'b1;
            rsp_result_q  <= rsp_result_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp_illegal_q <= rsp_illegal_d;
        end else if (rsp_clr_c) begin
            rsp_valid_q   <= 1'b0;
        end
    end

    assign bus.cmd_ready      = !fifo_full;
    assign bus.alu_opcode     = alu_opcode_q;
    assign bus.alu_input1     = alu_a_q;
    assign bus.alu_input2     = alu_b_q;
    assign bus.alu_shiftValue = alu_shift_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_result     = rsp_result_q;
    assign bus.rsp_flags      = rsp_flags_q;
    assign bus.rsp_illegal    = rsp_illegal_q;
    assign bus.busy           = (state_q != IDLE) || !fifo_empty;
    assign bus.fifo_level     = fifo_level;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: stand-in ALU, directed vectors,
// backpressure, randomized traffic against a response queue model, and reset.
module tb_alu_cmd_sequencer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam logic [42:0] RESET_VEC = {1'b1, 42'd0};

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [8:0] alu_wide;

    alu_cmd_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU; drives junk carry/overflow for logic and illegal ops
    always_comb begin
        alu_wide         = '0;
        bus.alu_carry    = 1'b1;
        bus.alu_overflow = 1'b1;
        bus.alu_zero     = 1'b0;
        bus.alu_result   = bus.alu_input1 ^ bus.alu_input2 ^ 8'hA5;
        case (bus.alu_opcode)
            4'd0: begin
                alu_wide         = {1'b0, bus.alu_input1} + {1'b0, bus.alu_input2};
                bus.alu_result   = alu_wide[7:0];
                bus.alu_carry    = alu_wide[8];
                bus.alu_overflow = (bus.alu_input1[7] == bus.alu_input2[7]) && (alu_wide[7] != bus.alu_input1[7]);
                bus.alu_zero     = (alu_wide[7:0] == 8'd0);
            end
            4'd1: begin
                alu_wide         = {1'b0, bus.alu_input1} - {1'b0, bus.alu_input2};
                bus.alu_result   = alu_wide[7:0];
                bus.alu_carry    = alu_wide[8];
                bus.alu_overflow = (bus.alu_input1[7] != bus.alu_input2[7]) && (alu_wide[7] != bus.alu_input1[7]);
                bus.alu_zero     = (alu_wide[7:0] == 8'd0);
            end
            4'd2: begin
                bus.alu_result = bus.alu_input1 & bus.alu_input2;
                bus.alu_zero   = ((bus.alu_input1 & bus.alu_input2) == 8'd0);
            end
            4'd3: begin
                bus.alu_result = bus.alu_input1 | bus.alu_input2;
                bus.alu_zero   = ((bus.alu_input1 | bus.alu_input2) == 8'd0);
            end
            default: ;
        endcase
    end

    // Expected response {illegal, carry, zero, overflow, result} from integer arithmetic
    function automatic logic [11:0] exp_rsp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, r;
        logic c, v;
        logic [7:0] res;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            4'd0: begin r = int'(a) + int'(b); res = 8'(r); c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'd1: begin r = int'(a) - int'(b); res = 8'(r); c = (int'(a) < int'(b)); v = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: begin res = a & b; c = 1'b0; v = 1'b0; end
            4'd3: begin res = a | b; c = 1'b0; v = 1'b0; end
            default: return {1'b1, 3'b010, 8'h00};
        endcase
        return {1'b0, c, (res == 8'd0), v, res};
    endfunction

    function automatic logic [11:0] rsp_vec();
        return {bus.rsp_illegal, bus.rsp_flags, bus.rsp_result};
    endfunction

    function automatic logic [42:0] out_vec();
        return {bus.cmd_ready, bus.alu_opcode, bus.alu_input1, bus.alu_input2, bus.alu_shiftValue,
                bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_illegal, bus.busy, bus.fifo_level};
    endfunction

    function automatic logic [3:0] rand_op();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(4, 15));
        return 4'($urandom_range(0, 3));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [4:0] sh);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_shift  = sh;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_vec() !== RESET_VEC) $display("FAIL reset_outputs[%0d]: got %h want %h", i, out_vec(), RESET_VEC);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_directed();
        logic [3:0]  ops  [5];
        logic [7:0]  as   [5];
        logic [7:0]  bs   [5];
        logic [11:0] exps [5];
        logic [4:0]  sh;
        ops  = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd3};
        as   = '{8'h7F, 8'h00, 8'hF0, 8'h55, 8'h0C};
        bs   = '{8'h01, 8'h01, 8'h0F, 8'hAA, 8'h30};
        exps = '{{1'b0, 3'b001, 8'h80}, {1'b0, 3'b100, 8'hFF}, {1'b0, 3'b010, 8'h00},
                 {1'b1, 3'b010, 8'h00}, {1'b0, 3'b000, 8'h3C}};
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sh = 5'(i + 3);
            drive_cmd(ops[i], as[i], bs[i], sh);
            n_checks++;
            if (bus.cmd_ready !== 1'b1) $display("FAIL dir%0d_cmd_ready: got %b want 1", i, bus.cmd_ready);
            else n_pass++;
            step();
            bus.cmd_valid = 1'b0;
            n_checks++;
            if ({bus.rsp_valid, bus.busy, bus.fifo_level} !== {1'b0, 1'b1, 3'd1})
                $display("FAIL dir%0d_accept: got v/busy/lvl %b/%b/%0d want 0/1/1", i, bus.rsp_valid, bus.busy, bus.fifo_level);
            else n_pass++;
            step();
            n_checks++;
            if ({bus.alu_opcode, bus.alu_input1, bus.alu_input2, bus.alu_shiftValue, bus.rsp_valid, bus.fifo_level} !==
                {ops[i], as[i], bs[i], sh, 1'b0, 3'd0})
                $display("FAIL dir%0d_issue: got op=%h a=%h b=%h sh=%0d v=%b lvl=%0d want op=%h a=%h b=%h sh=%0d v=0 lvl=0",
                         i, bus.alu_opcode, bus.alu_input1, bus.alu_input2, bus.alu_shiftValue, bus.rsp_valid,
                         bus.fifo_level, ops[i], as[i], bs[i], sh);
            else n_pass++;
            step();
            n_checks++;
            if ({bus.rsp_valid, rsp_vec()} !== {1'b1, exps[i]})
                $display("FAIL dir%0d_rsp: got v=%b rsp=%h want v=1 rsp=%h", i, bus.rsp_valid, rsp_vec(), exps[i]);
            else n_pass++;
            step();
            n_checks++;
            if ({bus.rsp_valid, bus.busy} !== 2'b00) $display("FAIL dir%0d_idle: got v/busy %b/%b want 0/0", i, bus.rsp_valid, bus.busy);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] q[$];
        int accepted = 0;
        int last;
        logic [3:0] op;
        logic [7:0] a, b;
        bus.rsp_ready = 1'b0;
        op = rand_op(); a = 8'($urandom); b = 8'($urandom);
        for (int i = 0; i < 7; i++) begin
            drive_cmd(op, a, b, 5'($urandom));
            if (bus.cmd_ready) begin
                q.push_back(exp_rsp(op, a, b));
                accepted++;
                op = rand_op(); a = 8'($urandom); b = 8'($urandom);
            end
            step();
        end
        bus.cmd_valid = 1'b0;
        n_checks++;
        if ({accepted, bus.cmd_ready, bus.fifo_level, bus.rsp_valid} !== {32'd5, 1'b0, 3'd4, 1'b1})
            $display("FAIL bp_fill: got acc=%0d rdy=%b lvl=%0d v=%b want acc=5 rdy=0 lvl=4 v=1",
                     accepted, bus.cmd_ready, bus.fifo_level, bus.rsp_valid);
        else n_pass++;
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if ({bus.rsp_valid, rsp_vec()} !== {1'b1, q[0]})
                $display("FAIL bp_stall%0d: got v=%b rsp=%h want v=1 rsp=%h", j, bus.rsp_valid, rsp_vec(), q[0]);
            else n_pass++;
            step();
        end
        // Release while still full: the pop frees a slot but the offered push is refused
        n_checks++;
        if (rsp_vec() !== q[0]) $display("FAIL bp_rsp0: got %h want %h", rsp_vec(), q[0]);
        else n_pass++;
        void'(q.pop_front());
        drive_cmd(4'd0, 8'h11, 8'h22, 5'd0);
        bus.rsp_ready = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        n_checks++;
        if ({bus.fifo_level, bus.rsp_valid} !== {3'd3, 1'b0})
            $display("FAIL bp_full_refuse: got lvl=%0d v=%b want lvl=3 v=0", bus.fifo_level, bus.rsp_valid);
        else n_pass++;
        last = 0;
        for (int cyc = 1; cyc < 30 && q.size() > 0; cyc++) begin
            if (bus.rsp_valid) begin
                n_checks++;
                if (rsp_vec() !== q[0]) $display("FAIL bp_order: got %h want %h", rsp_vec(), q[0]);
                else n_pass++;
                n_checks++;
                if (cyc - last != 2) $display("FAIL bp_rate: got gap %0d want 2", cyc - last);
                else n_pass++;
                void'(q.pop_front());
                last = cyc;
            end
            step();
        end
        n_checks++;
        if ({q.size(), bus.busy} !== {32'd0, 1'b0}) $display("FAIL bp_drain: got left=%0d busy=%b want 0/0", q.size(), bus.busy);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [11:0] q[$];
        logic [11:0] held = '0;
        logic stalled = 1'b0;
        logic [3:0] op;
        logic [7:0] a, b;
        for (int cyc = 0; cyc < 600; cyc++) begin
            op = rand_op(); a = 8'($urandom); b = 8'($urandom);
            drive_cmd(op, a, b, 5'($urandom));
            bus.cmd_valid = ($urandom_range(0, 2) != 0);
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
            n_checks++;
            if (bus.cmd_ready !== (bus.fifo_level != 3'(DEPTH)))
                $display("FAIL rnd_ready: got rdy=%b lvl=%0d want rdy=%b", bus.cmd_ready, bus.fifo_level, bus.fifo_level != 3'(DEPTH));
            else n_pass++;
            if (stalled) begin
                n_checks++;
                if ({bus.rsp_valid, rsp_vec()} !== {1'b1, held})
                    $display("FAIL rnd_hold: got v=%b rsp=%h want v=1 rsp=%h", bus.rsp_valid, rsp_vec(), held);
                else n_pass++;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL rnd_spurious: got rsp=%h want none", rsp_vec());
                else if (rsp_vec() !== q[0]) $display("FAIL rnd_rsp: got %h want %h", rsp_vec(), q.pop_front());
                else begin n_pass++; void'(q.pop_front()); end
            end
            if (bus.cmd_valid && bus.cmd_ready) q.push_back(exp_rsp(op, a, b));
            stalled = bus.rsp_valid && !bus.rsp_ready;
            held    = rsp_vec();
            step();
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && q.size() > 0; cyc++) begin
            if (bus.rsp_valid) begin
                n_checks++;
                if (rsp_vec() !== q[0]) $display("FAIL rnd_drain_rsp: got %h want %h", rsp_vec(), q[0]);
                else n_pass++;
                void'(q.pop_front());
            end
            step();
        end
        n_checks++;
        if ({q.size(), bus.busy, bus.rsp_valid} !== {32'd0, 1'b0, 1'b0})
            $display("FAIL rnd_drain: got left=%0d busy=%b v=%b want 0/0/0", q.size(), bus.busy, bus.rsp_valid);
        else n_pass++;
    endtask

    task automatic test_reset_inflight();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(4'(i), 8'($urandom), 8'($urandom), 5'($urandom));
            step();
        end
        bus.cmd_valid = 1'b0;
        n_checks++;
        if ({bus.rsp_valid, bus.fifo_level} !== {1'b1, 3'd3})
            $display("FAIL rst_setup: got v=%b lvl=%0d want v=1 lvl=3", bus.rsp_valid, bus.fifo_level);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_vec() !== RESET_VEC) $display("FAIL rst_async: got %h want %h", out_vec(), RESET_VEC);
        else n_pass++;
        step();
        step();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if ({bus.rsp_valid, bus.busy, bus.fifo_level} !== {1'b0, 1'b0, 3'd0})
                $display("FAIL rst_stale%0d: got v=%b busy=%b lvl=%0d want 0/0/0", i, bus.rsp_valid, bus.busy, bus.fifo_level);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_a      = '0;
        bus.cmd_b      = '0;
        bus.cmd_shift  = '0;
        bus.rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-queue and issue stage that sits directly upstream of the generated 8-bit ALU and feeds it. It buffers operation requests arriving on a valid/ready stream and drives one operation at a time onto the ALU's registered inputs. It then captures the ALU's combinational result and flags into a response register, which is presented downstream with valid/ready backpressure.

## Interface
- WIDTH, 8, operand/result width; must match the ALU bit width.
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_opcode  in  4  ALU opcode (ADD=0, SUB=1, AND=2, OR=3).
- cmd_a, cmd_b  in  WIDTH  operands.
- cmd_shift  in  5  shift amount, passed through unused.
- alu_opcode  out  4  registered, to ALU opcode.
- alu_input1, alu_input2  out  WIDTH  registered, to ALU operands.
- alu_shiftValue  out  5  registered, to ALU shiftValue.
- alu_result  in  WIDTH  from ALU.
- alu_carry, alu_zero, alu_overflow  in  1  ALU flags.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  downstream accepts.
- rsp_result  out  WIDTH  captured result.
- rsp_flags  out  3  {carry, zero, overflow}.
- rsp_illegal  out  1  opcode was >3.
- busy  out  1  state ≠ IDLE or FIFO non-empty.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Reset (async, immediate) clears all outputs: cmd_ready=1, alu_* = 0, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_illegal=0, busy=0, fifo_level=0. FIFO is emptied, state becomes IDLE, and any in-flight operation is dropped.
- Push: cmd_valid && cmd_ready at the edge writes {opcode, a, b, shift} to the tail.
- Push is refused when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full leaves fifo_level unchanged.
- FSM states are IDLE, ISSUE and RESP.
- IDLE: if the FIFO is non-empty, pop the head into the alu_* registers and go to ISSUE.
- ISSUE: lasts exactly one cycle. At its closing edge, capture the response and go to RESP.
- RESP: rsp_valid=1. On rsp_ready:
  - if the FIFO is non-empty, pop into alu_* and go to ISSUE;
  - otherwise go to IDLE.
  - rsp_valid falls unless a new capture occurs (it cannot occur in the same cycle).
- Response data holds stable while rsp_valid && !rsp_ready.
- Capture rules:
  - Opcode 0/1: rsp_result=alu_result, with carry, zero and overflow taken from the ALU.
  - Opcode 2/3: rsp_result=alu_result, zero from the ALU; carry and overflow are forced to 0.
  - Opcode 4–15: rsp_result=0, flags={0,1,0}, rsp_illegal=1; ALU outputs are ignored.
- alu_* registers hold their last value in IDLE and RESP.
- Total buffering is DEPTH+1 commands: DEPTH in the FIFO plus one in ISSUE/RESP.

## Timing
- Latency: a command accepted at edge T into an empty FIFO in IDLE drives alu_* from edge T+1, and rsp_valid rises at edge T+2.
- Throughput: one operation per 2 cycles with rsp_ready held high (RESP→ISSUE→RESP).
- cmd_ready is registered-state only and has no combinational path from rsp_ready.
- The ALU is purely combinational. Its outputs must settle within the ISSUE cycle.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams ADD/SUB/AND/OR;
  - flag bit indices CARRY=2, ZERO=1, OVF=0;
  - the FSM state encoding;
  - the MAX_LEGAL_OP=3 constant.
- One sub-module, alu_cmd_fifo: synchronous FIFO of width 4+WIDTH+WIDTH+5 with full, empty and level outputs, using the same async active-low reset.

## Test plan
- ADD a=0x7F, b=0x01, rsp_ready=1 → rsp_valid two edges after acceptance; rsp_result=0x80, flags={0,0,1}, rsp_illegal=0.
- SUB a=0x00, b=0x01 → rsp_result=0xFF, carry=1, zero=0, overflow=0.
- AND a=0xF0, b=0x0F → rsp_result=0x00, flags={0,1,0}.
- Opcode 4'd9 with a=0x55, b=0xAA → rsp_result=0x00, flags={0,1,0}, rsp_illegal=1.
- Backpressure, with rsp_ready=0:
  - offer 7 back-to-back commands → exactly 5 accepted, then cmd_ready=0, fifo_level=4;
  - raise rsp_ready → responses arrive in order, one every 2 cycles, with data stable while stalled.
- Reset: assert rst_n=0 in RESP with 3 commands queued → all outputs return to reset values immediately; after release, no stale response appears and fifo_level=0.
